multi_mode_ff_reg: RTL
======================

MULTI_MODE_FF_REG -- requirements
Module: multi_mode_ff_reg

Interface
REQ-001 Parameter WIDTH, default 4: number of flip-flop bits; legal range 1..32.
REQ-002 Parameter CNT_W, default 8: width of the change counter; legal range 2..16.
REQ-003 clk  input  1: single clock; all state updates on the rising edge.
REQ-004 rst  input  1: synchronous, active-high reset.
REQ-005 mode  input  2: operating mode. 00=D, 01=T, 10=JK, 11=SR. Applies to all bits.
REQ-006 en  input  1: update enable; 0 = all bits hold.
REQ-007 a  input  WIDTH: per-bit primary input, used as D, T, J or S depending on mode.
REQ-008 b  input  WIDTH: per-bit secondary input, used as K or R; ignored in D and T modes.
REQ-009 clr  input  1: synchronous clear of sr_err and chg_cnt.
REQ-010 q  output  WIDTH: registered flip-flop state.
REQ-011 qn  output  WIDTH: always ~q (combinational from q).
REQ-012 chg  output  WIDTH: registered per-bit flag; 1 if that bit changed on the previous edge.
REQ-013 sr_err  output  1: sticky flag for an illegal SR input combination.
REQ-014 chg_cnt  output  CNT_W: saturating count of edges on which any q bit changed.

Function
REQ-015 Per-bit next state when en=1 is set by mode.
- D: q<=a.
- T: q<=q^a.
- JK: 00 hold, 01 reset, 10 set, 11 toggle.
- SR: 00 hold, 01 reset, 10 set, 11 hold.
REQ-016 en=0 SHALL hold q regardless of mode, a or b; chg SHALL be 0 on the following cycle.
REQ-017 q SHALL change only at a rising clk edge; latency from inputs to q is 1 cycle.
REQ-018 chg SHALL be registered as (next_q ^ q) and be valid in the same cycle as the updated q.
REQ-019 chg SHALL be asserted for exactly one cycle per change; a bit toggling on consecutive edges keeps chg[i]=1 continuously.
REQ-020 sr_err SHALL set on an edge where en=1, mode=11 and any bit has a[i]=b[i]=1.
REQ-021 sr_err SHALL stay set until rst, or until clr is asserted on an edge with no new illegal condition.
REQ-022 If clr and a new illegal SR condition occur on the same edge, sr_err SHALL be 1 (set wins).
REQ-023 chg_cnt SHALL increment by 1 on each edge where next_q != q.
REQ-024 chg_cnt SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-025 clr SHALL set chg_cnt to 0; if a change occurs on the same edge, chg_cnt SHALL be 1.
REQ-026 A mode change takes effect on the next edge; no state other than q is kept per mode.
REQ-027 clr SHALL NOT affect q or chg.

Reset
REQ-028 rst has priority over en, mode and clr. Values on the edge after rst=1:
- q=0, qn=all ones, chg=0, sr_err=0, chg_cnt=0.
REQ-029 A reset mid-operation SHALL discard any pending update in that cycle.
REQ-030 The first update after reset SHALL occur on the first edge where rst=0 and en=1.

Verification (WIDTH=4, CNT_W=8)
REQ-031 Reset, then T mode, en=1, a=4'b0001 held for 4 edges.
- Required: q=1,0,1,0; chg=4'b0001 every cycle; chg_cnt=4.
REQ-032 D mode, a=4'hA, then en=0 with a=4'h5 for 3 edges.
- Required: q=4'hA held; chg=0 after the first hold edge; chg_cnt unchanged.
REQ-033 JK mode from q=4'h0 with {a,b} per bit = {10,01,11,00}.
- Required: q=4'b1010; a second identical edge gives q=4'b1000.
REQ-034 SR mode, a=4'b0011, b=4'b0010.
- Required: bit1 held, bit0 set, sr_err=1.
- Then clr=1 with legal inputs: sr_err=0.
- clr=1 together with a=b=4'b0001: sr_err stays 1.
REQ-035 T mode with a=4'hF for 300 edges.
- Required: chg_cnt saturates at 255.
- Then clr: chg_cnt=1 if a change occurs on the clr edge, otherwise 0.
REQ-036 Assert rst for 1 cycle in the middle of REQ-031.
- Required: q=0 and chg_cnt=0 on the next cycle.
- Toggling resumes from 0 after rst is released.

Source files
------------

// File: rtl/multi_mode_ff_reg.sv
// -----------------------------------------------------------------------------
// multi_mode_ff_reg
//
// A bank of WIDTH flip-flops that all behave as D, T, JK or SR flip-flops,
// selected by a shared mode input. Alongside the state it reports which bits
// changed on the last edge, keeps a sticky flag for illegal SR inputs, and
// counts (with saturation) the edges on which any bit changed.
//
// Parameters
//   WIDTH   : number of flip-flop bits (1..32)
//   CNT_W   : width of the change counter (2..16)
//
// Ports
//   clk     : clock, all state updates on the rising edge
//   rst     : synchronous active-high reset, highest priority
//   mode    : 00=D, 01=T, 10=JK, 11=SR (applies to all bits)
//   en      : update enable; 0 holds every bit
//   a       : per-bit D / T / J / S input
//   b       : per-bit K / R input (ignored in D and T modes)
//   clr     : synchronous clear of sr_err and chg_cnt (q and chg unaffected)
//   q       : registered flip-flop state
//   qn      : ~q
//   chg     : registered per-bit "changed on the previous edge" flags
//   sr_err  : sticky illegal-SR-combination flag
//   chg_cnt : saturating count of edges on which any q bit changed
// -----------------------------------------------------------------------------
module multi_mode_ff_reg #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             clr,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic [WIDTH-1:0] chg,
    output logic             sr_err,
    output logic [CNT_W-1:0] chg_cnt
);

    typedef enum logic [1:0] {
        MODE_D  = 2'b00,
        MODE_T  = 2'b01,
        MODE_JK = 2'b10,
        MODE_SR = 2'b11
    } ff_mode_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] next_q;
    logic             changed;
    logic             sr_illegal;

    // Next-state selection. With en low next_q equals q, so chg and the
    // counter naturally see "no change" on hold cycles.
    always_comb begin
        next_q = q;
        if (en) begin
            case (ff_mode_t'(mode))
                MODE_D:  next_q = a;
                MODE_T:  next_q = q ^ a;
                // Characteristic equation Q+ = J.~Q | ~K.Q
                MODE_JK: next_q = (a & ~q) | (~b & q);
                // Set when S only, reset when R only, otherwise hold
                // (S=R=1 holds and is flagged through sr_err).
                MODE_SR: next_q = (a & ~b) | (q & ~(b & ~a));
                default: next_q = q;
            endcase
        end
    end

    assign changed    = (next_q != q);
    assign sr_illegal = en && (mode == MODE_SR) && (|(a & b));

    always_ff @(posedge clk) begin
        if (rst) begin
            q       <= '0;
            chg     <= '0;
            sr_err  <= 1'b0;
            chg_cnt <= '0;
        end else begin
            q   <= next_q;
            chg <= next_q ^ q;

            // A new illegal condition wins over clr on the same edge.
            if (sr_illegal) begin
                sr_err <= 1'b1;
            end else if (clr) begin
                sr_err <= 1'b0;
            end

            // clr restarts the count, but a change on the same edge is
            // still counted so it is not lost.
            if (clr) begin
                chg_cnt <= changed ? CNT_W'(1) : '0;
            end else if (changed && (chg_cnt != CNT_MAX)) begin
                chg_cnt <= chg_cnt + CNT_W'(1);
            end
        end
    end

    assign qn = ~q;

endmodule
